// File: rtl/smart_room_pkg.sv
// Shared smart-room controller definitions: state encoding and default timing.
// Latency: n/a (package only).
// Backpressure: n/a.
package smart_room_pkg;

  // Common 3-bit state encoding used by the smart-room controllers
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_WINDOW   = 3'd2,
    ST_ALERT    = 3'd3,
    ST_COOLDOWN = 3'd4
  } state_e;

  localparam int DEF_WINDOW_CYC   = 64;
  localparam int DEF_HITS_NEEDED  = 3;
  localparam int DEF_COOLDOWN_CYC = 128;
  localparam int DEF_CNT_W        = 8;

endpackage

// File: rtl/alert_timer.sv
// Clearable up-counter that stops at a terminal value and flags it.
// Latency: clear/increment visible the cycle after they are sampled.
// Backpressure: none; counting holds at term_val, it never wraps.
module alert_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] term_val,
  output logic             term
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise step until the terminal value
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != term_val)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term = (cnt_q == term_val);

endmodule

// File: rtl/sound_alert_ctrl.sv
// Debounces detector match pulses into an alert with req/ack and a cooldown.
// Latency: alert_req rises the cycle after the threshold-reaching hit is sampled.
// Backpressure: alert_req is held until alert_ack; hits are ignored meanwhile.
module sound_alert_ctrl
  import smart_room_pkg::*;
#(
  parameter int WINDOW_CYC   = DEF_WINDOW_CYC,
  parameter int HITS_NEEDED  = DEF_HITS_NEEDED,
  parameter int COOLDOWN_CYC = DEF_COOLDOWN_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             det_hit,
  input  logic             alert_ack,
  output logic             det_rst,
  output logic             alert_req,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             busy
);

  localparam logic [CNT_W-1:0] WIN_TERM = CNT_W'(WINDOW_CYC - 1);
  localparam logic [CNT_W-1:0] CD_TERM  = CNT_W'(COOLDOWN_CYC - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W:0]   HITS_N   = (CNT_W + 1)'(HITS_NEEDED);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic             abort_q, abort_d;
  logic             det_rst_q, det_rst_d;
  logic             alert_req_q, alert_req_d;
  logic             busy_q, busy_d;

  logic             tmr_clr, tmr_inc, tmr_term;
  logic [CNT_W-1:0] tmr_term_val;
  logic [CNT_W:0]   hits_sum;
  logic             thresh;
  logic [CNT_W-1:0] hit_cnt_inc;

  // One timer serves both the hit window and the cooldown phase
  assign tmr_term_val = (state_q == ST_COOLDOWN) ? CD_TERM : WIN_TERM;

  alert_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .inc      (tmr_inc),
    .term_val (tmr_term_val),
    .term     (tmr_term)
  );

  assign hits_sum    = {1'b0, hit_cnt_q} + {{CNT_W{1'b0}}, det_hit};
  assign thresh      = (hits_sum >= HITS_N);
  assign hit_cnt_inc = (hit_cnt_q == {CNT_W{1'b1}}) ? hit_cnt_q : hit_cnt_q + ONE;

  // Next state, hit counter and timer control; outputs follow the next state
  always_comb begin
    state_d   = state_q;
    hit_cnt_d = hit_cnt_q;
    abort_d   = abort_q;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hit_cnt_d = '0;
        abort_d   = 1'b0;
        tmr_clr   = 1'b1;
        if (enable) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        hit_cnt_d = '0;
        tmr_clr   = 1'b1;
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (det_hit) begin
          hit_cnt_d = ONE;
          state_d   = (HITS_NEEDED == 1) ? ST_ALERT : ST_WINDOW;
        end
      end
      ST_WINDOW: begin
        tmr_inc = 1'b1;
        if (!enable) begin
          state_d   = ST_IDLE;
          hit_cnt_d = '0;
        end else begin
          if (det_hit) hit_cnt_d = hit_cnt_inc;
          // a hit on the expiry cycle still counts toward the threshold
          if (thresh) begin
            state_d = ST_ALERT;
          end else if (tmr_term) begin
            state_d   = ST_ARMED;
            hit_cnt_d = '0;
          end
        end
      end
      ST_ALERT: begin
        // disable is remembered so a raised request is never withdrawn
        if (!enable) abort_d = 1'b1;
        if (alert_ack) begin
          hit_cnt_d = '0;
          tmr_clr   = 1'b1;
          abort_d   = 1'b0;
          state_d   = (abort_q || !enable) ? ST_IDLE : ST_COOLDOWN;
        end
      end
      ST_COOLDOWN: begin
        tmr_inc = 1'b1;
        if (!enable)       state_d = ST_IDLE;
        else if (tmr_term) state_d = ST_ARMED;
      end
      default: begin
        state_d   = ST_IDLE;
        hit_cnt_d = '0;
        abort_d   = 1'b0;
      end
    endcase
    det_rst_d   = (state_d == ST_IDLE) || (state_d == ST_ALERT) || (state_d == ST_COOLDOWN);
    alert_req_d = (state_d == ST_ALERT);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hit_cnt_q   <= '0;
      abort_q     <= 1'b0;
      det_rst_q   <= 1'b1;
      alert_req_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hit_cnt_q   <= hit_cnt_d;
      abort_q     <= abort_d;
      det_rst_q   <= det_rst_d;
      alert_req_q <= alert_req_d;
      busy_q      <= busy_d;
    end
  end

  assign det_rst   = det_rst_q;
  assign alert_req = alert_req_q;
  assign hit_cnt   = hit_cnt_q;
  assign busy      = busy_q;

endmodule
